life_ram_sched: RTL and testbench
=================================

// Module: life_ram_sched
// PURPOSE
//  Time-slot scheduler for the single 512Kx8 async SRAM that holds the Life
//  bitmap. Shares the RAM between the life engine (one read window + one write
//  window per 8 pixel clocks) and the 1MHz-bus CPU port (reads and writes).
//  Generates registered SRAM cel/oel/wel/addr/data and returns read data.
//  Sits between video timing / life pipeline / bus interface and the RAM pins.
// PARAMETERS
//  ADDR_W   19      SRAM address width
//  DATA_W   8       SRAM data width
//  IDLE_ADDR all-1s Address driven when no window is active
// PORTS
//  clk_pixel     in   1       pixel clock (150MHz); the only clock
//  rst_n         in   1       asynchronous, active-low reset
//  line_start    in   1       1-cycle pulse, h_counter==0; realigns slot phase
//  active        in   1       display-active region (life engine owns slots)
//  run           in   1       control[7]: life engine write-back enabled
//  life_rd_addr  in   ADDR_W  life read address, sampled at read-window start
//  life_rd_data  out  DATA_W  byte read for the life engine
//  life_rd_valid out  1       1-cycle pulse, life_rd_data updated
//  life_wr_addr  in   ADDR_W  life write address, sampled at write-window start
//  life_wr_data  in   DATA_W  next-gen byte, sampled at write-window start
//  cpu_req       in   1       level request, held until cpu_ack
//  cpu_rnw       in   1       1=read, 0=write; stable while cpu_req
//  cpu_addr      in   ADDR_W  CPU address; stable while cpu_req
//  cpu_wdata     in   DATA_W  CPU write data; stable while cpu_req
//  cpu_ack       out  1       1-cycle pulse, CPU access complete
//  cpu_rdata     out  DATA_W  CPU read data, valid with cpu_ack
//  ram_addr      out  ADDR_W  SRAM address
//  ram_dout      out  DATA_W  SRAM write data
//  ram_doe       out  1       1 = drive ram_dout onto SRAM data pins
//  ram_din       in   DATA_W  SRAM data pins (input side)
//  ram_cel       out  1       SRAM chip enable, active low
//  ram_oel       out  1       SRAM output enable, active low
//  ram_wel       out  1       SRAM write enable, active low
// BEHAVIOUR
//  - Reset: phase=0, window=IDLE, cel/oel/wel=1, ram_addr=IDLE_ADDR, doe=0,
//    ram_dout=0, life_rd_valid=0, cpu_ack=0, life_rd_data=0, cpu_rdata=0.
//  - 3-bit phase counter increments every cycle, wraps 7->0. line_start forces
//    phase to 0 on the next edge. Windows: A = phase 0-3, B = phase 4-7.
//  - Window kind chosen on the edge entering phase 0 or 4 (incl. line_start):
//    A: active -> LREAD; else cpu_req -> CPU; else IDLE.
//    B: active&run -> LWRITE; else cpu_req -> CPU; else IDLE.
//    Priority: life engine always wins; CPU only in spare windows.
//  - Address/data latched at window start; inputs ignored mid-window.
//  - Read window (LREAD / CPU read), k=0..3: cel=0, oel=0, wel=1, doe=0;
//    ram_din sampled on the edge ending k=3. Result + life_rd_valid (or
//    cpu_rdata + cpu_ack) registered 1 cycle after window end.
//  - Write window (LWRITE / CPU write): cel=0, oel=1, doe=1 for k=0..3;
//    wel=0 only at k=1,2 (addr/data stable 1 cycle either side of wel).
//    cpu_ack 1 cycle after window end; no life-side completion signal.
//  - IDLE: cel=oel=wel=1, doe=0, ram_addr=IDLE_ADDR.
//  - All RAM outputs registered; never oel=0 and doe=1 together.
//  - cpu_req dropped mid-window: access still completes, ack still pulses.
//    Requester must drop cpu_req the cycle after ack; a new CPU window starts
//    no earlier than the next window boundary after ack.
//  - line_start mid-window: window truncated, next cycle is phase 0 with a new
//    decision; wel forced 1; truncated access gives no valid/ack (CPU retried
//    since cpu_req still high). line_start at phase 7->0 is a no-op realign.
//  - active falling mid-window: current window completes unchanged.
//  - rst_n asserted mid-window: all outputs to reset values immediately.
// TESTING
//  1 active=1,run=1, life_rd_addr=0x00010, RAM[0x10]=0xA5 -> A: cel=0,oel=0
//    phase0-3, life_rd_valid 1 cycle after, data 0xA5; B writes life_wr_data.
//  2 active=1,run=0, cpu write 0x12345<=0x3C -> taken in B, wel=0 at k=1,2
//    only, cpu_ack once; follow-up cpu read 0x12345 returns 0x3C.
//  3 active=1,run=1, cpu_req held 200 cycles -> no ack, no CPU window; drop
//    active -> ack at next window boundary + 5 cycles.
//  4 CPU write in progress at k=1, line_start pulse -> wel=1 next cycle, no
//    ack, write retried in later window, exactly one ack.
//  5 rst_n low at phase 2 of LREAD -> cel/oel/wel=1, addr=0x7FFFF, doe=0
//    immediately; no valid pulse after release.
//  6 Random CPU/active/run stimulus vs SRAM model -> doe&!oel never, all
//    CPU writes readable, one ack per request.

Source files
------------

// File: rtl/life_ram_sched_if.sv
// Bus bundle between the Life scheduler, its requesters and the SRAM pins.
// slave = scheduler side, master = video/life/CPU/SRAM environment side.
interface life_ram_sched_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              line_start;
    logic              active;
    logic              run;
    logic [ADDR_W-1:0] life_rd_addr;
    logic [DATA_W-1:0] life_rd_data;
    logic              life_rd_valid;
    logic [ADDR_W-1:0] life_wr_addr;
    logic [DATA_W-1:0] life_wr_data;
    logic              cpu_req;
    logic              cpu_rnw;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dout;
    logic              ram_doe;
    logic [DATA_W-1:0] ram_din;
    logic              ram_cel;
    logic              ram_oel;
    logic              ram_wel;

    modport slave (
        input  line_start, active, run,
        input  life_rd_addr, life_wr_addr, life_wr_data,
        output life_rd_data, life_rd_valid,
        input  cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        output ram_addr, ram_dout, ram_doe, ram_cel, ram_oel, ram_wel,
        input  ram_din
    );

    modport master (
        output line_start, active, run,
        output life_rd_addr, life_wr_addr, life_wr_data,
        input  life_rd_data, life_rd_valid,
        output cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        input  ram_addr, ram_dout, ram_doe, ram_cel, ram_oel, ram_wel,
        output ram_din
    );
endinterface

// File: rtl/life_ram_sched.sv
// Slot scheduler for the Life bitmap SRAM: 4-cycle windows A (life read) and
// B (life write), CPU accesses fill windows the life engine leaves spare.
module life_ram_sched #(
    parameter int                ADDR_W    = 19,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = '1
) (
    input  logic            clk_pixel,
    input  logic            rst_n,
    life_ram_sched_if.slave bus
);
    typedef enum logic [2:0] {W_IDLE, W_LREAD, W_LWRITE, W_CRD, W_CWR} win_e;

    win_e              win_q, win_d;
    logic [2:0]        phase_q, phase_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic              life_done_q, life_done_d;
    logic              cpu_done_q, cpu_done_d;
    logic              cpu_rd_done_q, cpu_rd_done_d;

    logic              cel_q, cel_d, oel_q, oel_d, wel_q, wel_d, doe_q, doe_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] lrd_q, lrd_d, crd_q, crd_d;
    logic              lvld_q, lvld_d, ack_q, ack_d;

    logic              k_last, boundary, cpu_fin, cpu_ok, rd_win, wr_win;

    // state register
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            win_q         <= W_IDLE;
            phase_q       <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            cap_q         <= '0;
            life_done_q   <= 1'b0;
            cpu_done_q    <= 1'b0;
            cpu_rd_done_q <= 1'b0;
            cel_q         <= 1'b1;
            oel_q         <= 1'b1;
            wel_q         <= 1'b1;
            doe_q         <= 1'b0;
            ram_addr_q    <= IDLE_ADDR;
            dout_q        <= '0;
            lrd_q         <= '0;
            crd_q         <= '0;
            lvld_q        <= 1'b0;
            ack_q         <= 1'b0;
        end else begin
            win_q         <= win_d;
            phase_q       <= phase_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cap_q         <= cap_d;
            life_done_q   <= life_done_d;
            cpu_done_q    <= cpu_done_d;
            cpu_rd_done_q <= cpu_rd_done_d;
            cel_q         <= cel_d;
            oel_q         <= oel_d;
            wel_q         <= wel_d;
            doe_q         <= doe_d;
            ram_addr_q    <= ram_addr_d;
            dout_q        <= dout_d;
            lrd_q         <= lrd_d;
            crd_q         <= crd_d;
            lvld_q        <= lvld_d;
            ack_q         <= ack_d;
        end
    end

    // next-state: phase, window decision, completion capture
    always_comb begin
        phase_d  = bus.line_start ? 3'd0 : phase_q + 3'd1;
        k_last   = (phase_q[1:0] == 2'd3);
        boundary = (phase_d[1:0] == 2'd0);
        cpu_fin  = ((win_q == W_CRD) || (win_q == W_CWR)) && k_last;
        // Block a second CPU window until the current access has been acked;
        // a truncated CPU window does not count, so it is simply retried.
        cpu_ok   = bus.cpu_req && !cpu_fin && !cpu_done_q;

        win_d   = win_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (boundary) begin
            if (!phase_d[2] && bus.active) begin
                win_d  = W_LREAD;
                addr_d = bus.life_rd_addr;
            end else if (phase_d[2] && bus.active && bus.run) begin
                win_d   = W_LWRITE;
                addr_d  = bus.life_wr_addr;
                wdata_d = bus.life_wr_data;
            end else if (cpu_ok) begin
                win_d   = bus.cpu_rnw ? W_CRD : W_CWR;
                addr_d  = bus.cpu_addr;
                wdata_d = bus.cpu_wdata;
            end else begin
                win_d = W_IDLE;
            end
        end

        life_done_d   = (win_q == W_LREAD) && k_last;
        cpu_done_d    = cpu_fin;
        cpu_rd_done_d = (win_q == W_CRD) && k_last;
        cap_d         = cap_q;
        if (((win_q == W_LREAD) || (win_q == W_CRD)) && k_last)
            cap_d = bus.ram_din;
    end

    // outputs: pin levels for the cycle we are entering, plus result stage
    always_comb begin
        rd_win     = (win_d == W_LREAD) || (win_d == W_CRD);
        wr_win     = (win_d == W_LWRITE) || (win_d == W_CWR);
        cel_d      = (win_d == W_IDLE);
        oel_d      = !rd_win;
        doe_d      = wr_win;
        // wel only in the middle two cycles so addr/data settle around it
        wel_d      = !(wr_win && ((phase_d[1:0] == 2'd1) || (phase_d[1:0] == 2'd2)));
        ram_addr_d = (win_d == W_IDLE) ? IDLE_ADDR : addr_d;
        dout_d     = wr_win ? wdata_d : dout_q;

        lvld_d = life_done_q;
        lrd_d  = life_done_q ? cap_q : lrd_q;
        ack_d  = cpu_done_q;
        crd_d  = cpu_rd_done_q ? cap_q : crd_q;
    end

    assign bus.ram_cel       = cel_q;
    assign bus.ram_oel       = oel_q;
    assign bus.ram_wel       = wel_q;
    assign bus.ram_doe       = doe_q;
    assign bus.ram_addr      = ram_addr_q;
    assign bus.ram_dout      = dout_q;
    assign bus.life_rd_data  = lrd_q;
    assign bus.life_rd_valid = lvld_q;
    assign bus.cpu_ack       = ack_q;
    assign bus.cpu_rdata     = crd_q;
endmodule

// File: tb/tb_life_ram_sched.sv
// Directed bench for life_ram_sched with a byte-array SRAM model on the pins.
module tb_life_ram_sched;
    localparam int AW = 19;
    localparam int DW = 8;

    logic clk_pixel = 1'b0;
    logic rst_n     = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    life_ram_sched_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    life_ram_sched #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    logic [7:0] mem [0:(1<<19)-1];
    int n_chk = 0, n_bad = 0;
    int viol = 0, ack_cnt = 0, lv_cnt = 0;
    bit rnd_on = 1'b0;

    assign bus.ram_din = (!bus.ram_cel && !bus.ram_oel) ? mem[bus.ram_addr] : 8'h00;

    always @(negedge clk_pixel) begin
        if (bus.ram_doe && !bus.ram_oel) viol++;
        if (bus.cpu_ack) ack_cnt++;
        if (bus.life_rd_valid) lv_cnt++;
        if (!bus.ram_wel && !bus.ram_cel && bus.ram_doe) mem[bus.ram_addr] = bus.ram_dout;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_pixel);
        #1;
    endtask

    task automatic wait_ack(input int max, output int cyc);
        cyc = 0;
        while (!bus.cpu_ack && cyc < max) begin
            tick(1);
            cyc++;
        end
    endtask

    function automatic logic [3:0] pins();
        return {bus.ram_cel, bus.ram_oel, bus.ram_wel, bus.ram_doe};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int a0, l0, cyc, idx, nreq;
        logic wr;
        logic [7:0] shadow [0:15];

        bus.line_start = 0; bus.active = 0; bus.run = 0;
        bus.life_rd_addr = '0; bus.life_wr_addr = '0; bus.life_wr_data = '0;
        bus.cpu_req = 0; bus.cpu_rnw = 1; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        for (int i = 0; i < (1<<19); i++) mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
        mem[19'h00010] = 8'hA5;

        // reset state
        #23;
        chk("rst_pins", pins(), 4'b1110);
        chk("rst_addr", bus.ram_addr, 19'h7FFFF);
        chk("rst_flags", {bus.life_rd_valid, bus.cpu_ack}, 2'b00);
        chk("rst_data", {bus.life_rd_data, bus.cpu_rdata, bus.ram_dout}, 24'h0);
        rst_n = 1'b1;
        tick(3);

        // 1: life read in A, life write in B
        bus.active = 1; bus.run = 1;
        bus.life_rd_addr = 19'h00010; bus.life_wr_addr = 19'h00020; bus.life_wr_data = 8'h5A;
        bus.line_start = 1;
        tick(1); bus.line_start = 0;
        chk("t1_a_k0", pins(), 4'b0010);
        chk("t1_a_addr", bus.ram_addr, 19'h00010);
        tick(3);
        chk("t1_a_k3", pins(), 4'b0010);
        chk("t1_no_vld", bus.life_rd_valid, 1'b0);
        tick(1);
        chk("t1_b_k0", pins(), 4'b0111);
        chk("t1_b_addr", bus.ram_addr, 19'h00020);
        chk("t1_b_dout", bus.ram_dout, 8'h5A);
        tick(1);
        chk("t1_vld", bus.life_rd_valid, 1'b1);
        chk("t1_rdata", bus.life_rd_data, 8'hA5);
        chk("t1_b_k1", pins(), 4'b0101);
        tick(1);
        chk("t1_vld_pulse", bus.life_rd_valid, 1'b0);
        chk("t1_b_k2", pins(), 4'b0101);
        tick(1);
        chk("t1_b_k3", pins(), 4'b0111);
        chk("t1_mem", mem[19'h00020], 8'h5A);

        // 2: CPU write taken in B when run=0, then read back
        bus.run = 0;
        bus.cpu_req = 1; bus.cpu_rnw = 0; bus.cpu_addr = 19'h12345; bus.cpu_wdata = 8'h3C;
        a0 = ack_cnt;
        bus.line_start = 1;
        tick(1); bus.line_start = 0;
        chk("t2_a_life", pins(), 4'b0010);
        tick(4);
        chk("t2_k0", pins(), 4'b0111);
        chk("t2_addr", bus.ram_addr, 19'h12345);
        chk("t2_dout", bus.ram_dout, 8'h3C);
        tick(1); chk("t2_k1", pins(), 4'b0101);
        tick(1); chk("t2_k2", pins(), 4'b0101);
        tick(1); chk("t2_k3", pins(), 4'b0111);
        tick(1); chk("t2_ack_early", bus.cpu_ack, 1'b0);
        tick(1); chk("t2_ack", bus.cpu_ack, 1'b1);
        bus.cpu_req = 0;
        tick(1); chk("t2_ack_pulse", bus.cpu_ack, 1'b0);
        chk("t2_ack_once", ack_cnt - a0, 1);
        chk("t2_mem", mem[19'h12345], 8'h3C);
        bus.cpu_rnw = 1; bus.cpu_req = 1;
        wait_ack(100, cyc);
        chk("t2_rd_timeout", cyc < 100, 1'b1);
        chk("t2_rdata", bus.cpu_rdata, 8'h3C);
        bus.cpu_req = 0;
        tick(2);

        // 3: CPU starved while life owns both windows
        bus.active = 1; bus.run = 1;
        bus.cpu_req = 1; bus.cpu_rnw = 0; bus.cpu_addr = 19'h00100; bus.cpu_wdata = 8'h77;
        a0 = ack_cnt;
        tick(200);
        chk("t3_starve_ack", ack_cnt - a0, 0);
        chk("t3_starve_mem", mem[19'h00100], 8'h00);
        bus.active = 0; bus.line_start = 1;
        tick(1); bus.line_start = 0;
        chk("t3_cpu_win", pins(), 4'b0111);
        tick(4); chk("t3_ack_early", bus.cpu_ack, 1'b0);
        tick(1); chk("t3_ack", bus.cpu_ack, 1'b1);
        bus.cpu_req = 0;
        chk("t3_mem", mem[19'h00100], 8'h77);
        tick(2);

        // 4: line_start truncates CPU write at k=1
        bus.cpu_req = 1; bus.cpu_rnw = 0; bus.cpu_addr = 19'h00200; bus.cpu_wdata = 8'hC3;
        a0 = ack_cnt;
        bus.line_start = 1;
        tick(1); bus.line_start = 0;
        chk("t4_k0", pins(), 4'b0111);
        tick(1);
        chk("t4_k1", pins(), 4'b0101);
        bus.line_start = 1;
        tick(1); bus.line_start = 0;
        chk("t4_trunc_wel", bus.ram_wel, 1'b1);
        chk("t4_trunc_ack", bus.cpu_ack, 1'b0);
        tick(4); chk("t4_ack_early", bus.cpu_ack, 1'b0);
        tick(1); chk("t4_ack", bus.cpu_ack, 1'b1);
        bus.cpu_req = 0;
        tick(8);
        chk("t4_ack_once", ack_cnt - a0, 1);
        chk("t4_mem", mem[19'h00200], 8'hC3);

        // 5: reset in the middle of a life read
        bus.active = 1; bus.run = 0; bus.life_rd_addr = 19'h00010;
        bus.line_start = 1;
        tick(1); bus.line_start = 0;
        tick(2);
        chk("t5_pre", pins(), 4'b0010);
        l0 = lv_cnt;
        rst_n = 0; bus.active = 0;
        #1;
        chk("t5_pins", pins(), 4'b1110);
        chk("t5_addr", bus.ram_addr, 19'h7FFFF);
        chk("t5_rdata", bus.life_rd_data, 8'h00);
        tick(2);
        rst_n = 1;
        tick(12);
        chk("t5_no_vld", lv_cnt - l0, 0);

        // 6: random environment against the pin-level SRAM model
        a0 = ack_cnt; nreq = 0; viol = 0;
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    bus.active = 1'($urandom_range(0, 1));
                    bus.run = ($urandom_range(0, 3) == 0);
                    bus.life_rd_addr = 19'($urandom_range(0, 255));
                    bus.life_wr_addr = 19'($urandom_range(0, 255));
                    bus.life_wr_data = 8'($urandom);
                    bus.line_start = ($urandom_range(0, 7) == 0);
                    tick(1);
                    bus.line_start = 0;
                    tick(1 + $urandom_range(0, 10));
                end
            end
        join_none
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 15);
            wr = 1'($urandom_range(0, 1));
            bus.cpu_rnw = !wr;
            bus.cpu_addr = 19'h40000 + 19'(idx);
            bus.cpu_wdata = 8'($urandom);
            bus.cpu_req = 1;
            nreq++;
            wait_ack(400, cyc);
            chk("t6_timeout", cyc < 400, 1'b1);
            if (!wr) chk("t6_rdata", bus.cpu_rdata, shadow[idx]);
            else shadow[idx] = bus.cpu_wdata;
            bus.cpu_req = 0;
            tick(1 + $urandom_range(0, 3));
        end
        rnd_on = 1'b0;
        wait fork;
        bus.active = 0; bus.run = 0; bus.line_start = 0;
        tick(4);
        for (int i = 0; i < 16; i++) begin
            bus.cpu_rnw = 1; bus.cpu_addr = 19'h40000 + 19'(i); bus.cpu_req = 1;
            nreq++;
            wait_ack(100, cyc);
            chk("t6_final_to", cyc < 100, 1'b1);
            chk("t6_final_rd", bus.cpu_rdata, shadow[i]);
            bus.cpu_req = 0;
            tick(2);
        end
        tick(8);
        chk("t6_acks", ack_cnt - a0, nreq);
        chk("t6_doe_oel", viol, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
